// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipeline control logic: widths and the hazard controller state.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   localparam int unsigned STALL_CNT_W = 32;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_REDIRECT = 2'd1,
      HZ_HALTED   = 2'd2
   } hzd_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control: stage enables/flushes and PC update for dcache stalls, load-use bubbles,
// taken-branch redirect (held across icache misses), sticky halt, and a stall-cycle counter.
module pipeline_hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = $bits(word_t),
   parameter int REG_W  = $bits(regbits_t),
   parameter int CNT_W  = STALL_CNT_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ihit,
   input  logic              dhit,
   input  logic              dmemren,
   input  logic              dmemwen,
   input  logic              memren_ex,
   input  logic [REG_W-1:0]  regwrite_ex,
   input  logic [REG_W-1:0]  rs_id,
   input  logic [REG_W-1:0]  rt_id,
   input  logic              branch_taken_mem,
   input  logic [WORD_W-1:0] pc_bran_mem,
   input  logic              halt_wb,
   output logic              pc_en,
   output logic              pc_redirect,
   output logic [WORD_W-1:0] redirect_pc,
   output logic              ifid_en,
   output logic              idex_en,
   output logic              exmem_en,
   output logic              memwb_en,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic              flush_exmem,
   output logic              halt,
   output logic [CNT_W-1:0]  stall_count
);

   hzd_state_t        state_q, state_d;
   logic [WORD_W-1:0] redirect_pc_q, redirect_pc_d;
   logic              halt_q, halt_d;
   logic [CNT_W-1:0]  stall_count_q, stall_count_d;

   logic load_use;
   logic mem_stall;
   logic stall_inc;

   assign load_use  = memren_ex && (regwrite_ex != '0) &&
                      ((regwrite_ex == rs_id) || (regwrite_ex == rt_id));
   assign mem_stall = (dmemren || dmemwen) && !dhit;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q       <= HZ_RUN;
         redirect_pc_q <= '0;
         halt_q        <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         halt_q        <= halt_d;
         stall_count_q <= stall_count_d;
      end
   end

   // Priority decode: the first matching rule owns every output for the cycle.
   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      halt_d        = halt_q;
      pc_en         = 1'b0;
      pc_redirect   = 1'b0;
      redirect_pc   = redirect_pc_q;
      ifid_en       = 1'b0;
      idex_en       = 1'b0;
      exmem_en      = 1'b0;
      memwb_en      = 1'b0;
      flush_ifid    = 1'b0;
      flush_idex    = 1'b0;
      flush_exmem   = 1'b0;

      if (!nRST) begin
         state_d = HZ_RUN;
      end else if (state_q == HZ_HALTED) begin
         halt_d = 1'b1;
      end else if (halt_wb) begin
         state_d = HZ_HALTED;
         halt_d  = 1'b1;
      end else if (mem_stall) begin
         state_d = state_q;
      end else if (dhit) begin
         memwb_en = 1'b1;
      end else if (state_q == HZ_RUN && branch_taken_mem) begin
         flush_ifid    = 1'b1;
         flush_idex    = 1'b1;
         flush_exmem   = 1'b1;
         memwb_en      = 1'b1;
         redirect_pc_d = pc_bran_mem;
         // The target is not latched yet, so a same-cycle PC load takes it straight from MEM.
         if (ihit) begin
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
            redirect_pc = pc_bran_mem;
         end else begin
            state_d = HZ_REDIRECT;
         end
      end else if (state_q == HZ_REDIRECT) begin
         pc_redirect = 1'b1;
         flush_idex  = 1'b1;
         exmem_en    = 1'b1;
         memwb_en    = 1'b1;
         if (ihit) begin
            pc_en      = 1'b1;
            flush_ifid = 1'b1;
            state_d    = HZ_RUN;
         end
      end else if (load_use || !ihit) begin
         flush_idex = 1'b1;
         exmem_en   = 1'b1;
         memwb_en   = 1'b1;
      end else begin
         pc_en    = 1'b1;
         ifid_en  = 1'b1;
         idex_en  = 1'b1;
         exmem_en = 1'b1;
         memwb_en = 1'b1;
      end
   end

   // Counts every cycle IF/ID is held while the core is live; sticks at all-ones.
   always_comb begin
      stall_inc     = nRST && (state_q != HZ_HALTED) && !ifid_en;
      stall_count_d = stall_count_q;
      if (stall_inc && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   assign halt        = halt_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl plus hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;
   localparam int CNT_W  = 4;

   localparam logic [8:0] ALL1    = 9'b1_0_1_1_1_1_000;
   localparam logic [8:0] BUB     = 9'b0_0_0_0_1_1_010;
   localparam logic [8:0] ZERO    = 9'b0_0_0_0_0_0_000;
   localparam logic [8:0] DHIT    = 9'b0_0_0_0_0_1_000;
   localparam logic [8:0] BR_MISS = 9'b0_0_0_0_0_1_111;
   localparam logic [8:0] BR_HIT  = 9'b1_1_0_0_0_1_111;
   localparam logic [8:0] RD_IDLE = 9'b0_1_0_0_1_1_010;
   localparam logic [8:0] RD_HIT  = 9'b1_1_0_0_1_1_110;

   typedef struct {
      logic              ihit;
      logic              dhit;
      logic              dmemren;
      logic              dmemwen;
      logic              memren_ex;
      logic [REG_W-1:0]  regwrite_ex;
      logic [REG_W-1:0]  rs_id;
      logic [REG_W-1:0]  rt_id;
      logic              branch_taken_mem;
      logic [WORD_W-1:0] pc_bran_mem;
      logic              halt_wb;
   } stim_t;

   typedef struct {
      stim_t      in;
      logic [8:0] exp;
   } vec_t;

   logic              CLK;
   logic              nRST;
   logic              ihit, dhit, dmemren, dmemwen, memren_ex;
   logic [REG_W-1:0]  regwrite_ex, rs_id, rt_id;
   logic              branch_taken_mem;
   logic [WORD_W-1:0] pc_bran_mem;
   logic              halt_wb;
   logic              pc_en, pc_redirect;
   logic [WORD_W-1:0] redirect_pc;
   logic              ifid_en, idex_en, exmem_en, memwb_en;
   logic              flush_ifid, flush_idex, flush_exmem;
   logic              halt;
   logic [CNT_W-1:0]  stall_count;

   int checks = 0;
   int errors = 0;
   vec_t tbl[12];

   pipeline_hazard_ctrl #(.WORD_W(WORD_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemren(dmemren), .dmemwen(dmemwen),
      .memren_ex(memren_ex), .regwrite_ex(regwrite_ex), .rs_id(rs_id), .rt_id(rt_id),
      .branch_taken_mem(branch_taken_mem), .pc_bran_mem(pc_bran_mem), .halt_wb(halt_wb),
      .pc_en(pc_en), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
      .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
      .halt(halt), .stall_count(stall_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic stim_t mk(input logic ih, input logic dh, input logic dr, input logic dw,
                                input logic mr, input logic [REG_W-1:0] rw,
                                input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                input logic br, input logic [WORD_W-1:0] pcb, input logic hw);
      stim_t s;
      s.ihit = ih; s.dhit = dh; s.dmemren = dr; s.dmemwen = dw; s.memren_ex = mr;
      s.regwrite_ex = rw; s.rs_id = rs; s.rt_id = rt;
      s.branch_taken_mem = br; s.pc_bran_mem = pcb; s.halt_wb = hw;
      return s;
   endfunction

   function automatic logic [8:0] outs();
      return {pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
              flush_ifid, flush_idex, flush_exmem};
   endfunction

   task automatic apply_stimulus(input stim_t s);
      ihit = s.ihit; dhit = s.dhit; dmemren = s.dmemren; dmemwen = s.dmemwen;
      memren_ex = s.memren_ex; regwrite_ex = s.regwrite_ex; rs_id = s.rs_id; rt_id = s.rt_id;
      branch_taken_mem = s.branch_taken_mem; pc_bran_mem = s.pc_bran_mem; halt_wb = s.halt_wb;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs, check outputs mid-cycle, then advance past the edge.
   task automatic cycle(input string name, input stim_t s, input logic [8:0] exp);
      apply_stimulus(s);
      @(negedge CLK);
      check_output(name, 32'(outs()), 32'(exp));
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      apply_stimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #3;
      check_output("reset_outs", 32'(outs()), 32'(ZERO));
      check_output("reset_halt", 32'(halt), 32'd0);
      check_output("reset_stall", 32'(stall_count), 32'd0);
      check_output("reset_rpc", redirect_pc, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0), ALL1};
      tbl[1]  = '{mk(1, 0, 0, 0, 1, 5, 5, 0, 0, 0,     0), BUB};
      tbl[2]  = '{mk(1, 0, 0, 0, 1, 7, 1, 7, 0, 0,     0), BUB};
      tbl[3]  = '{mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0,     0), ALL1};
      tbl[4]  = '{mk(1, 0, 0, 0, 0, 9, 9, 9, 0, 0,     0), ALL1};
      tbl[5]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0), BUB};
      tbl[6]  = '{mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,     0), ZERO};
      tbl[7]  = '{mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0,     0), ZERO};
      tbl[8]  = '{mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0,     0), DHIT};
      tbl[9]  = '{mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 'h100, 0), ZERO};
      tbl[10] = '{mk(0, 0, 0, 0, 1, 3, 0, 3, 0, 0,     0), BUB};
      tbl[11] = '{mk(1, 0, 0, 0, 1, 4, 5, 6, 0, 0,     0), ALL1};

      do_reset();

      // T1: free-running fetch
      for (int i = 0; i < 10; i++) cycle($sformatf("t1_c%0d", i), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ALL1);
      check_output("t1_stall", 32'(stall_count), 32'd0);

      for (int i = 0; i < 12; i++) cycle($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);
      check_output("vec_stall", 32'(stall_count), 32'd8);
      check_output("vec_rpc", redirect_pc, 32'd0);

      // T2: single load-use bubble
      do_reset();
      cycle("t2_bubble", mk(1, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0), BUB);
      cycle("t2_resume", mk(1, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0), ALL1);
      check_output("t2_stall", 32'(stall_count), 32'd2 - 32'd1);

      // T3: dcache miss then hit
      do_reset();
      for (int i = 0; i < 3; i++) cycle($sformatf("t3_miss%0d", i), mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), ZERO);
      cycle("t3_dhit", mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), DHIT);
      apply_stimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge CLK);
      check_output("t3_stall", 32'(stall_count), 32'd4);
      cycle("t3_advance", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ALL1);

      // T4: taken branch with icache miss, then with a hit
      do_reset();
      cycle("t4_branch", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0), BR_MISS);
      check_output("t4_rpc", redirect_pc, 32'h40);
      cycle("t4_idle0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RD_IDLE);
      cycle("t4_idle1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RD_IDLE);
      cycle("t4_ihit", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RD_HIT);
      cycle("t4_run", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ALL1);
      check_output("t4_stall", 32'(stall_count), 32'd4);
      check_output("t4_rpc_hold", redirect_pc, 32'h40);
      cycle("t4_br_hit", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0), BR_HIT);
      cycle("t4_run2", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ALL1);
      check_output("t4_rpc2", redirect_pc, 32'h80);

      // T5: sticky halt
      do_reset();
      apply_stimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1));
      @(negedge CLK);
      check_output("t5_halt_pre", 32'(halt), 32'd0);
      cycle("t5_halt_wb", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1), ZERO);
      for (int i = 0; i < 4; i++) cycle($sformatf("t5_held%0d", i), mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44, 0), ZERO);
      check_output("t5_halt", 32'(halt), 32'd1);
      check_output("t5_stall", 32'(stall_count), 32'd1);
      check_output("t5_rpc", redirect_pc, 32'd0);
      do_reset();
      check_output("t5_unhalt", 32'(halt), 32'd0);
      cycle("t5_run", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ALL1);

      // T6: asynchronous reset during REDIRECT, then counter saturation
      do_reset();
      cycle("t6_branch", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0), BR_MISS);
      cycle("t6_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RD_IDLE);
      #1;
      nRST = 1'b0;
      #1;
      check_output("t6_async_outs", 32'(outs()), 32'(ZERO));
      check_output("t6_async_rpc", redirect_pc, 32'd0);
      do_reset();
      check_output("t6_rpc_after", redirect_pc, 32'd0);
      cycle("t6_run", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ALL1);
      for (int i = 0; i < 14; i++) cycle($sformatf("t6_stall%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), BUB);
      check_output("t6_cnt_m1", 32'(stall_count), 32'd14);
      cycle("t6_stall14", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), BUB);
      check_output("t6_cnt_max", 32'(stall_count), 32'd15);
      for (int i = 0; i < 3; i++) cycle($sformatf("t6_sat%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), BUB);
      check_output("t6_cnt_sat", 32'(stall_count), 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
